mult_seq: RTL and testbench

Parametrised sequential shift-add multiplier. It is the next generation of the team's single-width iterative multiplier: operand widths are configurable, it retires STEP multiplier bits per cycle, it supports a per-operation signed/unsigned mode, and it terminates early once the remaining multiplier bits are zero. A one-cycle `done_o` pulse accompanies the result. It sits in the datapath as a multi-cycle arithmetic unit driven by a start/busy handshake.

---
 rtl/mult_seq.sv | 121 ++++++++++++
 tb/tb_mult_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier with configurable operand widths, STEP
// multiplier bits retired per cycle, optional signed mode and early exit
// once the remaining multiplier bits are all zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; y_bo holds the last product
// WORK  | one partial-product accumulation of STEP bits per cycle
module mult_seq #(
  parameter int A_W       = 16,
  parameter int B_W       = 8,
  parameter int STEP      = 1,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [A_W-1:0]   a_bi,
  input  logic [B_W-1:0]   b_bi,
  output logic             busy_o,
  output logic             done_o,
  output logic [A_W+B_W-1:0] y_bo
);

  localparam int P     = A_W + B_W;
  localparam int NSTEP = B_W / STEP;
  localparam int CW    = $clog2(NSTEP + 1);

  typedef enum logic {IDLE, WORK} state_t;

  state_t         state_q;
  logic [P-1:0]   acc_q;
  logic [P-1:0]   am_q;
  logic [B_W-1:0] bm_q;
  logic           neg_q;
  logic [CW-1:0]  cnt_q;
  logic [P-1:0]   y_q;
  logic           busy_q;
  logic           done_q;

  logic           sgn_sel;
  logic           a_neg_in;
  logic           b_neg_in;
  logic [A_W-1:0] a_mag;
  logic [B_W-1:0] b_mag;
  logic [P-1:0]   pp;
  logic [P-1:0]   acc_nxt;
  logic [P-1:0]   y_nxt;
  logic [B_W-1:0] bm_shr;
  logic           last_step;

  // Operand conditioning at start and the per-step accumulate/terminate logic.
  // Negating the most negative value in W bits yields 2^(W-1), which is
  // still correct when read as an unsigned magnitude.
  always_comb begin
    sgn_sel   = signed_i & (SIGNED_EN != 0);
    a_neg_in  = sgn_sel & a_bi[A_W-1];
    b_neg_in  = sgn_sel & b_bi[B_W-1];
    a_mag     = a_neg_in ? -a_bi : a_bi;
    b_mag     = b_neg_in ? -b_bi : b_bi;
    pp        = am_q * P'(bm_q[STEP-1:0]);
    acc_nxt   = acc_q + pp;
    y_nxt     = neg_q ? -acc_nxt : acc_nxt;
    bm_shr    = bm_q >> STEP;
    // Remaining multiplier bits exhausted, or the step budget is used up.
    last_step = (bm_shr == '0) || (cnt_q == CW'(1));
  end

  // Control FSM and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      am_q    <= '0;
      bm_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            neg_q   <= a_neg_in ^ b_neg_in;
            am_q    <= P'(a_mag);
            bm_q    <= b_mag;
            acc_q   <= '0;
            cnt_q   <= CW'(NSTEP);
            busy_q  <= 1'b1;
            state_q <= WORK;
          end
        end
        WORK: begin
          if (last_step) begin
            y_q     <= y_nxt;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= acc_nxt;
            am_q  <= am_q << STEP;
            bm_q  <= bm_shr;
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign y_bo   = y_q;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: three builds share operand inputs (default, STEP=2,
// SIGNED_EN=0), each with its own start and outputs. Expected products and
// latencies come from plain integer arithmetic on the operands.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  start = '0;
  logic        sgn = 1'b0;
  logic [15:0] a = '0;
  logic [7:0]  b = '0;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [23:0] y [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_seq #(.A_W(16), .B_W(8), .STEP(1), .SIGNED_EN(1)) u_dut_s1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .signed_i(sgn),
    .a_bi(a), .b_bi(b), .busy_o(busy[0]), .done_o(done[0]), .y_bo(y[0]));

  mult_seq #(.A_W(16), .B_W(8), .STEP(2), .SIGNED_EN(1)) u_dut_s2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .signed_i(sgn),
    .a_bi(a), .b_bi(b), .busy_o(busy[1]), .done_o(done[1]), .y_bo(y[1]));

  mult_seq #(.A_W(16), .B_W(8), .STEP(1), .SIGNED_EN(0)) u_dut_us (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .signed_i(sgn),
    .a_bi(a), .b_bi(b), .busy_o(busy[2]), .done_o(done[2]), .y_bo(y[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product truncated to 24 bits; latency from the
  // position of the highest set bit of |b|.
  task automatic model(input int d, input logic [15:0] av, input logic [7:0] bv,
                       input logic sg, output logic [23:0] ey, output int en);
    bit     s;
    int     step;
    longint ai, bi, p, bmag;
    int     hb;
    s    = sg && (d != 2);
    step = (d == 1) ? 2 : 1;
    ai   = s ? longint'($signed(av)) : longint'(av);
    bi   = s ? longint'($signed(bv)) : longint'(bv);
    p    = ai * bi;
    ey   = p[23:0];
    bmag = (bi < 0) ? -bi : bi;
    hb   = -1;
    for (int i = 0; i < 9; i++) if (bmag[i]) hb = i;
    en   = (hb < 0) ? 1 : (hb + step) / step;
  endtask

  task automatic run_op(input int d, input logic [15:0] av, input logic [7:0] bv,
                        input logic sg, input bit inj);
    logic [23:0] ey;
    int en, lat;
    model(d, av, bv, sg, ey, en);
    @(negedge clk);
    a = av; b = bv; sgn = sg; start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    a = 16'($urandom); b = 8'($urandom); sgn = 1'($urandom);
    chk("busy_rise", busy[d], 1);
    chk("done_early", done[d], 0);
    lat = 0;
    while (!done[d] && lat < 40) begin
      if (inj && lat == 1) begin
        start[d] = 1'b1; a = ~av; b = 8'h7F; sgn = ~sg;
      end else begin
        start[d] = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (!done[d]) chk("busy_hold", busy[d], 1);
    end
    start[d] = 1'b0;
    chk("latency", lat, en);
    chk("product", y[d], ey);
    chk("busy_fall", busy[d], 0);
    @(negedge clk);
    chk("done_pulse", done[d], 0);
  endtask

  task automatic b2b(input int d);
    logic [15:0] ra [3];
    logic [7:0]  rb [3];
    logic        rs [3];
    logic [23:0] ey;
    int en, lat;
    for (int k = 0; k < 3; k++) begin
      ra[k] = 16'($urandom); rb[k] = 8'($urandom_range(0, 255)); rs[k] = 1'($urandom);
    end
    @(negedge clk);
    a = ra[0]; b = rb[0]; sgn = rs[0]; start[d] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      model(d, ra[k], rb[k], rs[k], ey, en);
      @(negedge clk);
      chk("b2b_busy", busy[d], 1);
      chk("b2b_done_lo", done[d], 0);
      lat = 0;
      while (!done[d] && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk("b2b_latency", lat, en);
      chk("b2b_product", y[d], ey);
      if (k < 2) begin
        a = ra[k+1]; b = rb[k+1]; sgn = rs[k+1];
      end else begin
        start[d] = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_end_done", done[d], 0);
    chk("b2b_end_busy", busy[d], 0);
  endtask

  task automatic reset_mid_op();
    bit seen;
    @(negedge clk);
    a = 16'($urandom); b = 8'h80 | 8'($urandom); sgn = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y0", y[0], 0);
    chk("rst_y1", y[1], 0);
    chk("rst_y2", y[2], 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done != 3'b000 || busy != 3'b000) seen = 1'b1;
    end
    chk("rst_no_done", seen, 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_done", done, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_y", y[0], 0);

    // Directed corners
    run_op(0, 16'hFFFF, 8'hFF, 1'b0, 1'b0);
    run_op(0, 16'hFFFD, 8'h05, 1'b1, 1'b0);
    run_op(0, 16'h8000, 8'h80, 1'b1, 1'b0);
    run_op(0, 16'h1234, 8'h00, 1'b1, 1'b0);
    run_op(0, 16'h1234, 8'h03, 1'b0, 1'b0);
    run_op(2, 16'hFFFF, 8'h02, 1'b1, 1'b0);
    run_op(2, 16'h8000, 8'h80, 1'b1, 1'b0);
    run_op(1, 16'hFFFF, 8'hFF, 1'b0, 1'b0);
    run_op(1, 16'h1234, 8'h04, 1'b0, 1'b0);
    run_op(1, 16'h8000, 8'h80, 1'b1, 1'b0);
    run_op(0, 16'h7FFF, 8'h7F, 1'b1, 1'b0);
    run_op(0, 16'h0000, 8'hFF, 1'b1, 1'b0);

    // Start pulsed mid-operation is ignored
    run_op(0, 16'h1357, 8'h9B, 1'b0, 1'b1);
    run_op(1, 16'hF00D, 8'hC3, 1'b1, 1'b1);

    // Randomized
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 15; i++) begin
        logic [7:0] rb;
        rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
        run_op(d, 16'($urandom), rb, 1'($urandom), 1'b0);
      end
    end

    // Back-to-back with start held high
    b2b(0);
    b2b(1);

    // Asynchronous reset in the middle of an operation
    reset_mid_op();
    run_op(0, 16'hFFFF, 8'hFF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
